// File: rtl/demux1a4_descp_cond.sv
// 1:4 round-robin lane demux: assembles 4-word groups from one serial stream, flushes stalled partial groups.
// Latency 1 cycle after the completing word; no backpressure, every valid_in word is accepted.
module demux1a4_descp_cond #(
    parameter int DATA_W   = 8,
    parameter int IDLE_MAX = 4
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              validout0,
    output logic              validout1,
    output logic              validout2,
    output logic              validout3,
    output logic [DATA_W-1:0] dataout0,
    output logic [DATA_W-1:0] dataout1,
    output logic [DATA_W-1:0] dataout2,
    output logic [DATA_W-1:0] dataout3,
    output logic              group_done,
    output logic              partial_flush
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_MAX - 1);

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [3:0]        filled, filled_nxt;
    logic [7:0]        idle_cnt, idle_nxt;
    logic [DATA_W-1:0] stage [4];

    logic [3:0]        vld, vld_nxt;
    logic [DATA_W-1:0] dout [4];
    logic [DATA_W-1:0] dout_nxt [4];
    logic              gd, gd_nxt;
    logic              pf, pf_nxt;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        filled_nxt = filled;
        idle_nxt   = idle_cnt;
        vld_nxt    = 4'b0000;
        gd_nxt     = 1'b0;
        pf_nxt     = 1'b0;
        for (int k = 0; k < 4; k++) dout_nxt[k] = dout[k];

        if (valid_in) begin
            idle_nxt = 8'd0;
            if (ptr == 2'd3) begin
                // Lane 3 comes straight from the completing word, not from stage.
                vld_nxt     = 4'b1111;
                gd_nxt      = 1'b1;
                dout_nxt[0] = stage[0];
                dout_nxt[1] = stage[1];
                dout_nxt[2] = stage[2];
                dout_nxt[3] = data_in;
                ptr_nxt     = 2'd0;
                filled_nxt  = 4'b0000;
                state_nxt   = IDLE;
            end else begin
                filled_nxt[ptr] = 1'b1;
                ptr_nxt         = ptr + 2'd1;
                state_nxt       = FILL;
            end
        end else if (state == FILL) begin
            if (idle_cnt == IDLE_LAST) begin
                vld_nxt = filled;
                pf_nxt  = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (filled[k]) dout_nxt[k] = stage[k];
                end
                ptr_nxt    = 2'd0;
                filled_nxt = 4'b0000;
                idle_nxt   = 8'd0;
                state_nxt  = IDLE;
            end else begin
                idle_nxt = idle_cnt + 8'd1;
            end
        end else begin
            idle_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            filled   <= 4'b0000;
            idle_cnt <= 8'd0;
            vld      <= 4'b0000;
            gd       <= 1'b0;
            pf       <= 1'b0;
            for (int k = 0; k < 4; k++) dout[k] <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            filled   <= filled_nxt;
            idle_cnt <= idle_nxt;
            vld      <= vld_nxt;
            gd       <= gd_nxt;
            pf       <= pf_nxt;
            for (int k = 0; k < 4; k++) dout[k] <= dout_nxt[k];
        end
    end

    // Stage contents need no reset: the filled mask decides what is ever read out.
    always_ff @(posedge clk_4f) begin
        if (valid_in) stage[ptr] <= data_in;
    end

    assign validout0     = vld[0];
    assign validout1     = vld[1];
    assign validout2     = vld[2];
    assign validout3     = vld[3];
    assign dataout0      = dout[0];
    assign dataout1      = dout[1];
    assign dataout2      = dout[2];
    assign dataout3      = dout[3];
    assign group_done    = gd;
    assign partial_flush = pf;

endmodule

// File: tb/tb_demux1a4_descp_cond.sv
// Bench for demux1a4_descp_cond: directed vector table, hand sequences and randomized traffic vs a queue-based model.
module tb_demux1a4_descp_cond;

    localparam int DW   = 8;
    localparam int IMAX = 4;

    logic          clk_4f = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          validout0, validout1, validout2, validout3;
    logic [DW-1:0] dataout0, dataout1, dataout2, dataout3;
    logic          group_done, partial_flush;

    demux1a4_descp_cond #(.DATA_W(DW), .IDLE_MAX(IMAX)) dut (
        .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .validout0(validout0), .validout1(validout1), .validout2(validout2), .validout3(validout3),
        .dataout0(dataout0), .dataout1(dataout1), .dataout2(dataout2), .dataout3(dataout3),
        .group_done(group_done), .partial_flush(partial_flush)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic        rst;
        logic        vin;
        logic [7:0]  din;
        logic [3:0]  vld;
        logic        gd;
        logic        pf;
        logic [31:0] dat;   // {lane0, lane1, lane2, lane3}
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a queue of pending words and an idle-run counter.
    logic [DW-1:0] pend[$];
    int            idle_run;
    logic [DW-1:0] m_dat [4];
    logic [3:0]    m_vld;
    logic          m_gd, m_pf;

    function automatic vec_t mkv(logic r, logic v, logic [7:0] d, logic [3:0] ev,
                                 logic eg, logic ep, logic [31:0] ed);
        vec_t t;
        t.rst = r; t.vin = v; t.din = d; t.vld = ev; t.gd = eg; t.pf = ep; t.dat = ed;
        return t;
    endfunction

    function automatic logic [37:0] observed();
        return {validout3, validout2, validout1, validout0, group_done, partial_flush,
                dataout0, dataout1, dataout2, dataout3};
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [DW-1:0] d);
        m_vld = 4'b0000; m_gd = 1'b0; m_pf = 1'b0;
        if (r) begin
            pend.delete();
            idle_run = 0;
            for (int k = 0; k < 4; k++) m_dat[k] = '0;
        end else if (v) begin
            pend.push_back(d);
            idle_run = 0;
            if (pend.size() == 4) begin
                for (int k = 0; k < 4; k++) m_dat[k] = pend[k];
                m_vld = 4'b1111;
                m_gd  = 1'b1;
                pend.delete();
            end
        end else if (pend.size() > 0) begin
            idle_run++;
            if (idle_run == IMAX) begin
                for (int k = 0; k < pend.size(); k++) begin
                    m_dat[k] = pend[k];
                    m_vld[k] = 1'b1;
                end
                m_pf = 1'b1;
                pend.delete();
                idle_run = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), then sample at the next negedge.
    task automatic run_cycle(input logic r, input logic v, input logic [DW-1:0] d, input string name);
        reset = r; valid_in = v; data_in = d;
        model_step(r, v, d);
        @(negedge clk_4f);
        check(name, observed(), {m_vld, m_gd, m_pf, m_dat[0], m_dat[1], m_dat[2], m_dat[3]});
    endtask

    int gd_pos[$];

    initial begin
        reset = 1'b1; valid_in = 1'b1; data_in = 8'hFF;
        idle_run = 0;
        for (int k = 0; k < 4; k++) m_dat[k] = '0;
        #2;

        // reset with valid high, one full group, then a flushed partial group
        tbl.push_back(mkv(1, 1, 8'hFF, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(1, 1, 8'hFF, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'hA0, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'hA1, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'hA2, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'hA3, 4'hF, 1, 0, 32'hA0A1A2A3));
        tbl.push_back(mkv(0, 1, 8'h11, 4'h0, 0, 0, 32'hA0A1A2A3));
        tbl.push_back(mkv(0, 1, 8'h22, 4'h0, 0, 0, 32'hA0A1A2A3));
        tbl.push_back(mkv(0, 0, 8'h00, 4'h0, 0, 0, 32'hA0A1A2A3));
        tbl.push_back(mkv(0, 0, 8'h00, 4'h0, 0, 0, 32'hA0A1A2A3));
        tbl.push_back(mkv(0, 0, 8'h00, 4'h0, 0, 0, 32'hA0A1A2A3));
        tbl.push_back(mkv(0, 0, 8'h00, 4'h3, 0, 1, 32'h1122A2A3));
        tbl.push_back(mkv(0, 0, 8'h00, 4'h0, 0, 0, 32'h1122A2A3));
        // 2-cycle gaps stay under the timeout
        for (int i = 0; i < 4; i++) begin
            logic [7:0] w;
            w = 8'h10 * 8'(i + 1);
            tbl.push_back(mkv(0, 1, w, (i == 3) ? 4'hF : 4'h0, i == 3, 0,
                              (i == 3) ? 32'h10203040 : 32'h1122A2A3));
            if (i < 3) begin
                tbl.push_back(mkv(0, 0, 8'h00, 4'h0, 0, 0, 32'h1122A2A3));
                tbl.push_back(mkv(0, 0, 8'h00, 4'h0, 0, 0, 32'h1122A2A3));
            end
        end
        // reset mid-group drops staged words
        tbl.push_back(mkv(0, 1, 8'h01, 4'h0, 0, 0, 32'h10203040));
        tbl.push_back(mkv(0, 1, 8'h02, 4'h0, 0, 0, 32'h10203040));
        tbl.push_back(mkv(0, 1, 8'h03, 4'h0, 0, 0, 32'h10203040));
        tbl.push_back(mkv(1, 0, 8'h00, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'h04, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'h05, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'h06, 4'h0, 0, 0, 32'h00000000));
        tbl.push_back(mkv(0, 1, 8'h07, 4'hF, 1, 0, 32'h04050607));

        foreach (tbl[i]) begin
            run_cycle(tbl[i].rst, tbl[i].vin, tbl[i].din, $sformatf("model_vec%0d", i));
            check($sformatf("table_vec%0d", i), observed(),
                  {tbl[i].vld, tbl[i].gd, tbl[i].pf, tbl[i].dat});
        end

        // back-to-back groups: group_done exactly on the 4th and 8th word
        for (int i = 0; i < 8; i++) begin
            run_cycle(0, 1, 8'hB0 + 8'(i), $sformatf("b2b_w%0d", i));
            if (group_done === 1'b1) gd_pos.push_back(i);
        end
        n_cmp++;
        if (gd_pos.size() != 2 || gd_pos[0] != 3 || gd_pos[1] != 7) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d pulses (first at %0d), required 2 at 3 and 7",
                     gd_pos.size(), (gd_pos.size() > 0) ? gd_pos[0] : -1);
        end

        // word arriving on the would-be timeout cycle prevents the flush
        run_cycle(0, 1, 8'hC0, "late_w0");
        for (int i = 0; i < IMAX - 1; i++) run_cycle(0, 0, 8'h00, $sformatf("late_idle%0d", i));
        run_cycle(0, 1, 8'hC1, "late_w1");
        check("late_no_flush", {37'd0, partial_flush}, 38'd0);
        for (int i = 0; i < IMAX; i++) run_cycle(0, 0, 8'h00, $sformatf("late_tail%0d", i));
        check("late_flush_pf", {37'd0, partial_flush}, 38'd1);

        // randomized traffic, including long idle runs and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic r, v;
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 9) < 5);
            run_cycle(r, v, 8'($urandom), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
